// File: rtl/uart_stim_tx.sv
`timescale 1ns/1ps
// UART stimulus generator: queues words in a small FIFO and serialises them
// with a fixed baud divisor, word length, parity mode and stop-bit count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (line low) for CLK_DIV cycles
// S_DATA   | DATA_BITS data bits, LSB first, CLK_DIV cycles each
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | STOP_BITS stop bits; last cycle pulses tx_done, may chain to S_START
module uart_stim_tx #(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                                sys_clk,
   input  logic                                sys_rst_n,
   input  logic [DATA_BITS-1:0]                in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic                                serial_tx,
   output logic                                busy,
   output logic                                tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
   output logic [15:0]                         frame_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(FIFO_DEPTH+1);
   localparam int unsigned BW = $clog2(DATA_BITS+1);
   localparam logic [15:0]   BAUD_LOAD = 16'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [15:0]           baud_cnt;
   logic [BW-1:0]         bit_idx;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  parity_q;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  baud_tc;
   logic                  frame_end;
   logic [DATA_BITS-1:0]  head;

   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~(^d) : (^d);
   endfunction

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready   = !full;
   assign push       = in_valid && in_ready;
   assign fifo_level = LW'(wr_ptr - rd_ptr);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign baud_tc    = (baud_cnt == 16'd0);
   assign frame_end  = (state == S_STOP) && baud_tc && (bit_idx == LAST_STOP);
   // A pop happens either from idle or on the last stop cycle, so frames chain with no gap.
   assign pop        = !empty && ((state == S_IDLE) || frame_end);

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         rd_ptr      <= '0;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         serial_tx   <= 1'b1;
         tx_done     <= 1'b0;
         busy        <= 1'b0;
         frame_count <= '0;
      end else begin
         // Registered pulse lands on the final cycle of the last stop bit.
         tx_done <= (state == S_STOP) && (bit_idx == LAST_STOP) && (baud_cnt == 16'd1);
         busy    <= (state != S_IDLE) || !empty;

         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            shift_q  <= head;
            parity_q <= par_of(head);
         end

         if (frame_end) begin
            frame_count <= frame_count + 16'd1;
         end

         case (state)
            S_IDLE: begin
               serial_tx <= 1'b1;
               if (!empty) begin
                  state     <= S_START;
                  serial_tx <= 1'b0;
                  baud_cnt  <= BAUD_LOAD;
               end
            end

            S_START: begin
               if (baud_tc) begin
                  state     <= S_DATA;
                  serial_tx <= shift_q[0];
                  baud_cnt  <= BAUD_LOAD;
                  bit_idx   <= '0;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            S_DATA: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     if (PARITY != 0) begin
                        state     <= S_PARITY;
                        serial_tx <= parity_q;
                     end else begin
                        state     <= S_STOP;
                        serial_tx <= 1'b1;
                     end
                  end else begin
                     bit_idx   <= bit_idx + BW'(1);
                     shift_q   <= shift_q >> 1;
                     serial_tx <= shift_q[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            S_PARITY: begin
               if (baud_tc) begin
                  state     <= S_STOP;
                  serial_tx <= 1'b1;
                  baud_cnt  <= BAUD_LOAD;
                  bit_idx   <= '0;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            S_STOP: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     if (!empty) begin
                        state     <= S_START;
                        serial_tx <= 1'b0;
                     end else begin
                        state     <= S_IDLE;
                        serial_tx <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end

            default: begin
               state     <= S_IDLE;
               serial_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_stim_tx.sv
`timescale 1ns/1ps
// Bench for uart_stim_tx: three instances (8N1, 7O2, 7E2) at CLK_DIV=4, depth 4.
module tb_uart_stim_tx;

   localparam int CD = 4;

   logic        sys_clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   logic [7:0]  in_data;
   logic [2:0]  valid_v;
   logic [2:0]  ready_v;
   logic [2:0]  tx_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  lvl [3];
   logic [15:0] fc  [3];

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] exp_fc [3];

   typedef struct {
      int          inst;
      logic [7:0]  data;
      logic [11:0] bits;
      int          nbits;
      string       name;
   } vec_t;

   vec_t        vecs [10];
   logic [7:0]  b2b_words [6];

   always #5 sys_clk = ~sys_clk;

   uart_stim_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .sys_clk(sys_clk), .sys_rst_n(rst_a), .in_data(in_data), .in_valid(valid_v[0]),
      .in_ready(ready_v[0]), .serial_tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]),
      .fifo_level(lvl[0]), .frame_count(fc[0]));

   uart_stim_tx #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_o (
      .sys_clk(sys_clk), .sys_rst_n(rst_b), .in_data(in_data[6:0]), .in_valid(valid_v[1]),
      .in_ready(ready_v[1]), .serial_tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]),
      .fifo_level(lvl[1]), .frame_count(fc[1]));

   uart_stim_tx #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_e (
      .sys_clk(sys_clk), .sys_rst_n(rst_b), .in_data(in_data[6:0]), .in_valid(valid_v[2]),
      .in_ready(ready_v[2]), .serial_tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]),
      .fifo_level(lvl[2]), .frame_count(fc[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line order: bit 0 = start, then data LSB first, then stop.
   function automatic logic [11:0] frame8(input logic [7:0] d);
      return {3'b001, d, 1'b0};
   endfunction

   task automatic run_vec(input vec_t v);
      logic [11:0] seen;
      logic        stable;
      int          done_n;
      int          done_at;
      @(negedge sys_clk);
      in_data        = v.data;
      valid_v[v.inst] = 1'b1;
      @(negedge sys_clk);
      valid_v[v.inst] = 1'b0;
      check({v.name, "_level_after_push"}, 32'(lvl[v.inst]), 32'd1);
      seen    = '0;
      stable  = 1'b1;
      done_n  = 0;
      done_at = -1;
      for (int c = 0; c < v.nbits * CD; c++) begin
         @(negedge sys_clk);
         if (c % CD == 0) seen[c / CD] = tx_v[v.inst];
         else if (tx_v[v.inst] !== seen[c / CD]) stable = 1'b0;
         if (done_v[v.inst] === 1'b1) begin
            done_n++;
            done_at = c;
         end
         if (c == 0) check({v.name, "_level_after_pop"}, 32'(lvl[v.inst]), 32'd0);
         if (c == 2 * CD) check({v.name, "_busy"}, 32'(busy_v[v.inst]), 32'd1);
      end
      exp_fc[v.inst] = exp_fc[v.inst] + 16'd1;
      check({v.name, "_bits"}, 32'(seen), 32'(v.bits));
      check({v.name, "_bit_width"}, 32'(stable), 32'd1);
      check({v.name, "_done_count"}, 32'(done_n), 32'd1);
      check({v.name, "_done_cycle"}, 32'(done_at), 32'(v.nbits * CD - 1));
      @(negedge sys_clk);
      check({v.name, "_idle_line"}, 32'(tx_v[v.inst]), 32'd1);
      check({v.name, "_frame_count"}, 32'(fc[v.inst]), 32'(exp_fc[v.inst]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   bad;
      int   found;
      int   acc;
      int   rdy_bad;
      int   max_lvl;
      int   mism;
      int   dones;
      logic [11:0] fr;

      vecs[0] = '{0, 8'hA5, 12'h34A, 10, "a5_8n1"};
      vecs[1] = '{0, 8'h00, 12'h200, 10, "00_8n1"};
      vecs[2] = '{0, 8'hFF, 12'h3FE, 10, "ff_8n1"};
      vecs[3] = '{0, 8'h01, 12'h202, 10, "01_8n1"};
      vecs[4] = '{1, 8'h03, 12'h706, 11, "03_7o2"};
      vecs[5] = '{2, 8'h03, 12'h606, 11, "03_7e2"};
      vecs[6] = '{1, 8'h07, 12'h60E, 11, "07_7o2"};
      vecs[7] = '{2, 8'h07, 12'h70E, 11, "07_7e2"};
      vecs[8] = '{1, 8'h55, 12'h7AA, 11, "55_7o2"};
      vecs[9] = '{2, 8'h7F, 12'h7FE, 11, "7f_7e2"};
      b2b_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 3; i++) exp_fc[i] = 16'd0;

      rst_a   = 1'b0;
      rst_b   = 1'b0;
      in_data = 8'h00;
      valid_v = 3'b000;
      #12;
      for (int i = 0; i < 3; i++) begin
         check("rst_tx", 32'(tx_v[i]), 32'd1);
         check("rst_ready", 32'(ready_v[i]), 32'd1);
         check("rst_busy", 32'(busy_v[i]), 32'd0);
         check("rst_done", 32'(done_v[i]), 32'd0);
         check("rst_level", 32'(lvl[i]), 32'd0);
         check("rst_frame_count", 32'(fc[i]), 32'd0);
      end
      #8;
      rst_a = 1'b1;
      rst_b = 1'b1;

      bad = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge sys_clk);
         if (tx_v !== 3'b111 || busy_v !== 3'b000 || ready_v !== 3'b111 || done_v !== 3'b000) bad++;
      end
      check("idle_1000_cycles", 32'(bad), 32'd0);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      repeat (3) @(negedge sys_clk);

      // Six words back to back into a depth-4 FIFO; the line must be one unbroken waveform.
      acc = 0; rdy_bad = 0; max_lvl = 0; found = 0; mism = 0; dones = 0;
      fork
         begin
            for (int c = 0; c < 400 && acc < 6; c++) begin
               @(negedge sys_clk);
               if (ready_v[0] !== (lvl[0] != 3'd4)) rdy_bad++;
               if (int'(lvl[0]) > max_lvl) max_lvl = int'(lvl[0]);
               in_data    = b2b_words[acc];
               valid_v[0] = 1'b1;
               if (ready_v[0] === 1'b1) acc++;
            end
            @(negedge sys_clk);
            valid_v[0] = 1'b0;
         end
         begin
            for (int c = 0; c < 100; c++) begin
               @(negedge sys_clk);
               if (tx_v[0] === 1'b0) begin
                  found = 1;
                  break;
               end
            end
            if (found == 1) begin
               for (int c = 0; c < 6 * 10 * CD; c++) begin
                  if (c > 0) @(negedge sys_clk);
                  fr = frame8(b2b_words[c / (10 * CD)]);
                  if (tx_v[0] !== fr[(c % (10 * CD)) / CD]) mism++;
                  if (done_v[0] === 1'b1) dones++;
               end
            end
         end
      join
      exp_fc[0] = exp_fc[0] + 16'd6;
      check("b2b_start_seen", 32'(found), 32'd1);
      check("b2b_accepted", 32'(acc), 32'd6);
      check("b2b_ready_vs_full", 32'(rdy_bad), 32'd0);
      check("b2b_max_level", 32'(max_lvl), 32'd4);
      check("b2b_waveform", 32'(mism), 32'd0);
      check("b2b_done_pulses", 32'(dones), 32'd6);
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("b2b_frame_count", 32'(fc[0]), 32'(exp_fc[0]));
      check("b2b_idle_after", 32'(tx_v[0]), 32'd1);

      // Reset during the third data bit with two words still queued.
      repeat (3) @(negedge sys_clk);
      in_data = 8'h00; valid_v[0] = 1'b1;
      @(negedge sys_clk); in_data = 8'h5A;
      @(negedge sys_clk); in_data = 8'hC3;
      @(negedge sys_clk); valid_v[0] = 1'b0;
      repeat (12) @(negedge sys_clk);
      check("mid_tx_before_reset", 32'(tx_v[0]), 32'd0);
      check("mid_level_before_reset", 32'(lvl[0]), 32'd2);
      #2 rst_a = 1'b0;
      #1;
      check("mid_tx_async", 32'(tx_v[0]), 32'd1);
      check("mid_level_flushed", 32'(lvl[0]), 32'd0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst_a     = 1'b1;
      exp_fc[0] = 16'd0;
      check("mid_frame_count_clear", 32'(fc[0]), 32'd0);
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge sys_clk);
         if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || lvl[0] !== 3'd0) bad++;
      end
      check("mid_no_frame_after", 32'(bad), 32'd0);
      check("mid_frame_count_after", 32'(fc[0]), 32'd0);

      // Frame counter wrap.
      force u_a.frame_count = 16'hFFFF;
      @(negedge sys_clk);
      release u_a.frame_count;
      exp_fc[0] = 16'hFFFF;
      @(negedge sys_clk);
      check("wrap_preset", 32'(fc[0]), 32'h0000FFFF);
      run_vec('{0, 8'h3C, 12'h278, 10, "wrap_3c"});
      check("wrap_frame_count", 32'(fc[0]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/uart_stim_tx.md
# uart_stim_tx

Parametrised UART serial stimulus generator for simulation and hardware loop-back of the HDMI design's serial console. It drives the DUT `serial_rx` line with queued words, replacing the constant-idle `rx` drive. Words enter through a valid/ready port into an internal FIFO and are serialised with configurable baud divisor, word length, parity and stop bits. It sits beside the DUT in the bench and is also synthesisable for on-board self-test.

## Interface
- `CLK_DIV`, 868, sys_clk cycles per bit (115200 baud at 100 MHz); legal range 2..65535
- `DATA_BITS`, 8, data bits per frame; legal range 5..9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2
- `FIFO_DEPTH`, 16, word FIFO depth; power of two, 2..256

- `sys_clk` in 1 single clock, all logic rising-edge
- `sys_rst_n` in 1 reset, asynchronous assert, active-low
- `in_data` in DATA_BITS word to send, LSB first on the line
- `in_valid` in 1 word present
- `in_ready` out 1 FIFO not full; word accepted on edge where `in_valid && in_ready`
- `serial_tx` out 1 UART line, idle high
- `busy` out 1 frame in progress or FIFO non-empty
- `tx_done` out 1 one-cycle pulse at the end of each frame's last stop bit
- `fifo_level` out $clog2(FIFO_DEPTH+1) words currently queued, excluding the one being shifted
- `frame_count` out 16 frames completed since reset, wraps 65535 -> 0

## Operation
- Reset values: `serial_tx`=1, `in_ready`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, `frame_count`=0, FSM in IDLE, FIFO empty.
- FIFO: circular buffer, read/write pointers one bit wider than the address. `in_ready` = !full. A push while full is impossible because `in_ready`=0. A simultaneous push and pop leaves `fifo_level` unchanged.
- FSM states:
  - IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, compute parity, go to START.
  - START: line 0 for CLK_DIV cycles, then DATA.
  - DATA: DATA_BITS bits, LSB first, each held CLK_DIV cycles. Then PARITY if PARITY≠0, else STOP.
  - PARITY: odd mode sends XOR-reduce of the data inverted; even mode sends XOR-reduce of the data. Held CLK_DIV cycles, then STOP.
  - STOP: line 1 for STOP_BITS×CLK_DIV cycles. On the final cycle, pulse `tx_done` and increment `frame_count`. If the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: 16-bit, loaded with CLK_DIV-1 on each state/bit entry, decrements to 0, and advances on 0. Bit index counter is $clog2(DATA_BITS+1) wide.
- `busy` = (state≠IDLE) || (fifo_level≠0), registered.
- Reset mid-frame: `serial_tx` returns to 1 asynchronously, the frame is truncated, the FIFO is flushed, and counters clear. No partial `tx_done`.

## Timing
- Push at edge N into an empty FIFO while IDLE: `fifo_level`=1 after N; pop and `serial_tx`=0 after edge N+1; `fifo_level`=0 after N+1.
- Start bit falling edge to stop bit end is exactly (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×CLK_DIV cycles.
- `tx_done` is high during the final cycle of the last stop bit. The next frame's start bit (if queued) begins on the following edge.
- `in_ready` deasserts the cycle after the push that fills the FIFO, and reasserts the cycle after the pop.
- `frame_count` updates on the same edge that ends `tx_done`.

## Test plan
- Reset/idle: hold `sys_rst_n`=0 for 20 ns, then release with no input -> `serial_tx`=1, `busy`=0, `in_ready`=1 for 1000 cycles.
- Single frame, CLK_DIV=4, 8N1: push 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); start bit begins 2 edges after the push; one `tx_done`; `frame_count`=1.
- Parity/stop, CLK_DIV=4, DATA_BITS=7, PARITY=1, STOP_BITS=2: push 0x03 -> parity bit 1, two stop bits, frame 44 cycles. Rerun with PARITY=2 -> parity bit 0.
- Back-to-back/full, FIFO_DEPTH=4: push 6 words continuously -> `in_ready` drops when level reaches 4; all 6 frames are sent with zero idle cycles between them, in order; `frame_count`=6.
- Reset mid-frame: assert `sys_rst_n`=0 during the 3rd data bit with 2 words queued -> `serial_tx`=1 immediately; after release `fifo_level`=0, `frame_count`=0, and no frame is emitted.
- Counter wrap: force `frame_count`=65535 and send one frame -> `frame_count`=0.
